// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator machine: opcodes, controller states,
// mux/ALU select codes and the control word the controller drives each cycle.
package acc_pkg;

  localparam int OPW    = 4;
  localparam int STATEW = 4;

  localparam logic [OPW-1:0] OP_LW   = 4'h0;
  localparam logic [OPW-1:0] OP_SW   = 4'h1;
  localparam logic [OPW-1:0] OP_ADD  = 4'h2;
  localparam logic [OPW-1:0] OP_SUB  = 4'h3;
  localparam logic [OPW-1:0] OP_ADDI = 4'h4;
  localparam logic [OPW-1:0] OP_AND  = 4'h5;
  localparam logic [OPW-1:0] OP_OR   = 4'h6;
  localparam logic [OPW-1:0] OP_BEQZ = 4'h7;
  localparam logic [OPW-1:0] OP_JMP  = 4'h8;
  localparam logic [OPW-1:0] OP_PUSH = 4'h9;
  localparam logic [OPW-1:0] OP_POP  = 4'hA;
  localparam logic [OPW-1:0] OP_HALT = 4'hF;

  typedef enum logic [STATEW-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_ACCLD  = 4'd4,
    S_MEMWR  = 4'd5,
    S_ALUEX  = 4'd6,
    S_ACCWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_SPDEC  = 4'd10,
    S_PUSHWR = 4'd11,
    S_POPADR = 4'd12,
    S_POPRD  = 4'd13,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [2:0] SRCA_PC  = 3'd0;
  localparam logic [2:0] SRCA_ACC = 3'd1;
  localparam logic [2:0] SRCA_SP  = 3'd2;

  localparam logic [3:0] SRCB_CONST2 = 4'd0;
  localparam logic [3:0] SRCB_SE     = 4'd1;
  localparam logic [3:0] SRCB_MDR    = 4'd2;
  localparam logic [3:0] SRCB_ZE     = 4'd3;
  localparam logic [3:0] SRCB_SL1    = 4'd4;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_PASSB = 3'd4;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       acc_write;
    logic       acc_src;
    logic       sp_write;
    logic       aluout_write;
    logic       pc_src;
    logic       halted;
    logic [2:0] src_a;
    logic [3:0] src_b;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // ALU operation for the accumulator-update instructions in ALUEX.
  function automatic logic [2:0] alu_op_for(input logic [OPW-1:0] opcode);
    case (opcode)
      OP_SUB:  alu_op_for = ALU_SUB;
      OP_AND:  alu_op_for = ALU_AND;
      OP_OR:   alu_op_for = ALU_OR;
      default: alu_op_for = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/acc_ctrl_fsm_decode.sv
// Combinational state -> control word table. Opcode only selects the ALU
// operation/operand in ALUEX; Zero only gates the branch PC write.
module acc_ctrl_decode
  import acc_pkg::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output ctrl_t          ctrl
);

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = 1'b1;
        ctrl.src_a    = SRCA_PC;
        ctrl.src_b    = SRCB_CONST2;
        ctrl.alu_op   = ALU_ADD;
        ctrl.pc_write = 1'b1;
      end
      S_DECODE: begin
        ctrl.src_a        = SRCA_PC;
        ctrl.src_b        = SRCB_SL1;
        ctrl.alu_op       = ALU_ADD;
        ctrl.aluout_write = 1'b1;
      end
      S_MEMADR: begin
        ctrl.src_b        = SRCB_ZE;
        ctrl.alu_op       = ALU_PASSB;
        ctrl.aluout_write = 1'b1;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_ACCLD: begin
        ctrl.acc_write = 1'b1;
        ctrl.acc_src   = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_ALUEX: begin
        ctrl.src_a        = SRCA_ACC;
        ctrl.src_b        = (opcode == OP_ADDI) ? SRCB_SE : SRCB_MDR;
        ctrl.alu_op       = alu_op_for(opcode);
        ctrl.aluout_write = 1'b1;
      end
      S_ACCWB: ctrl.acc_write = 1'b1;
      // BEQZ encodes IR[11:0]=0, so ACC - SE(0) sets Zero exactly when ACC==0.
      S_BRANCH: begin
        ctrl.src_a    = SRCA_ACC;
        ctrl.src_b    = SRCB_SE;
        ctrl.alu_op   = ALU_SUB;
        ctrl.pc_write = zero;
        ctrl.pc_src   = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 1'b1;
      end
      S_SPDEC: begin
        ctrl.src_a        = SRCA_SP;
        ctrl.src_b        = SRCB_CONST2;
        ctrl.alu_op       = ALU_SUB;
        ctrl.sp_write     = 1'b1;
        ctrl.aluout_write = 1'b1;
      end
      S_PUSHWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_POPADR: begin
        ctrl.src_a        = SRCA_SP;
        ctrl.src_b        = SRCB_CONST2;
        ctrl.alu_op       = ALU_ADD;
        ctrl.sp_write     = 1'b1;
        ctrl.aluout_write = 1'b1;
      end
      S_POPRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/acc_ctrl_fsm.sv
// Multicycle controller for the 16-bit accumulator datapath: state register,
// next-state sequencing per opcode, and the decoded control outputs.
module acc_ctrl_fsm
  import acc_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic [OPW-1:0]    Opcode,
  input  logic              Zero,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              IorD,
  output logic              ACCWrite,
  output logic              ACCSrc,
  output logic              SPWrite,
  output logic              ALUOutWrite,
  output logic              PCSrc,
  output logic [2:0]        SrcA,
  output logic [3:0]        SrcB,
  output logic [2:0]        ALUOP,
  output logic              Halted,
  output logic [STATEW-1:0] State
);

  state_t state, state_next;
  ctrl_t  ctrl_raw, ctrl;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW, OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = S_MEMADR;
          OP_ADDI: state_next = S_ALUEX;
          OP_BEQZ: state_next = S_BRANCH;
          OP_JMP:  state_next = S_JUMP;
          OP_PUSH: state_next = S_SPDEC;
          OP_POP:  state_next = S_POPADR;
          OP_HALT: state_next = S_HALT;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = (Opcode == OP_LW) ? S_ACCLD : S_ALUEX;
      S_ALUEX:  state_next = S_ACCWB;
      S_SPDEC:  state_next = S_PUSHWR;
      S_POPADR: state_next = S_POPRD;
      S_POPRD:  state_next = S_ACCLD;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  acc_ctrl_decode u_decode (
    .state  (state),
    .opcode (Opcode),
    .zero   (Zero),
    .ctrl   (ctrl_raw)
  );

  // Reset forces every strobe low at once, not just from the next edge.
  assign ctrl = reset ? CTRL_IDLE : ctrl_raw;

  assign PCWrite     = ctrl.pc_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IorD        = ctrl.iord;
  assign ACCWrite    = ctrl.acc_write;
  assign ACCSrc      = ctrl.acc_src;
  assign SPWrite     = ctrl.sp_write;
  assign ALUOutWrite = ctrl.aluout_write;
  assign PCSrc       = ctrl.pc_src;
  assign SrcA        = ctrl.src_a;
  assign SrcB        = ctrl.src_b;
  assign ALUOP       = ctrl.alu_op;
  assign Halted      = ctrl.halted;
  assign State       = state;

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// Directed bench for acc_ctrl_fsm: one task per instruction class, each
// walking the expected state sequence and checking the control strobes.
module tb_acc_ctrl_fsm;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Opcode = 4'h0;
  logic       Zero = 1'b0;
  logic       PCWrite, IRWrite, MemRead, MemWrite, IorD, ACCWrite, ACCSrc;
  logic       SPWrite, ALUOutWrite, PCSrc, Halted;
  logic [2:0] SrcA, ALUOP;
  logic [3:0] SrcB, State;

  int total = 0;
  int bad = 0;

  acc_ctrl_fsm dut (
    .CLK(CLK), .reset(reset), .Opcode(Opcode), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .ACCWrite(ACCWrite), .ACCSrc(ACCSrc), .SPWrite(SPWrite),
    .ALUOutWrite(ALUOutWrite), .PCSrc(PCSrc), .SrcA(SrcA), .SrcB(SrcB),
    .ALUOP(ALUOP), .Halted(Halted), .State(State)
  );

  always #5 CLK = ~CLK;

  // Packed view of all enables/strobes (10 bits) for the "everything off" checks.
  wire [9:0] strobes = {PCWrite, IRWrite, MemRead, MemWrite, IorD, ACCWrite,
                        ACCSrc, SPWrite, ALUOutWrite, PCSrc};

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the FSM in FETCH, sampled 3 time units after a rising edge.
  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    step();
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge CLK); #3;
    reset = 1'b1;
    #1;
    total++;
    if (State !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", State); end
    total++;
    if ({strobes, SrcA, SrcB, ALUOP, Halted} !== 21'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {strobes, SrcA, SrcB, ALUOP, Halted});
    end
    reset = 1'b0;
    #1;
    total++;
    if ({MemRead, IRWrite, PCWrite, IorD, PCSrc, SrcA, SrcB, ALUOP} !== {3'b111, 2'b00, 3'd0, 4'd0, 3'd0}) begin
      bad++; $display("FAIL fetch_outputs got=%b", {MemRead, IRWrite, PCWrite, IorD, PCSrc, SrcA, SrcB, ALUOP});
    end
  endtask

  task automatic test_addi();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    int acc_writes = 0;
    do_reset();
    Opcode = 4'h4;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (State !== seq[i]) begin bad++; $display("FAIL addi_state[%0d] got=%0d exp=%0d", i, State, seq[i]); end
      if (i < 4 && ACCWrite) acc_writes++;
      if (i == 1) begin
        total++;
        if ({SrcA, SrcB, ALUOP, ALUOutWrite} !== {3'd0, 4'd4, 3'd0, 1'b1}) begin
          bad++; $display("FAIL addi_decode got=%b", {SrcA, SrcB, ALUOP, ALUOutWrite});
        end
      end
      if (i == 2) begin
        total++;
        if ({SrcA, SrcB, ALUOP, ALUOutWrite} !== {3'd1, 4'd1, 3'd0, 1'b1}) begin
          bad++; $display("FAIL addi_aluex got=%b", {SrcA, SrcB, ALUOP, ALUOutWrite});
        end
      end
      if (i == 3) begin
        total++;
        if ({ACCWrite, ACCSrc} !== 2'b10) begin bad++; $display("FAIL addi_accwb got=%b exp=10", {ACCWrite, ACCSrc}); end
      end
      step();
    end
    total++;
    if (acc_writes !== 1) begin bad++; $display("FAIL addi_accwrite_count got=%0d exp=1", acc_writes); end
  endtask

  task automatic test_reset_mid_aluex();
    do_reset();
    Opcode = 4'h4;
    step(); step();
    total++;
    if (State !== 4'd6) begin bad++; $display("FAIL midrst_pre got=%0d exp=6", State); end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (State !== 4'd0 || ACCWrite !== 1'b0) begin
      bad++; $display("FAIL midrst_immediate state=%0d accwrite=%b exp=0/0", State, ACCWrite);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (State !== 4'd0 || strobes !== 10'd0) begin
        bad++; $display("FAIL midrst_hold[%0d] state=%0d strobes=%b exp=0", i, State, strobes);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    do_reset();
    Opcode = 4'h0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (State !== seq[i]) begin bad++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, State, seq[i]); end
      if (i == 2) begin
        total++;
        if ({SrcB, ALUOP, ALUOutWrite} !== {4'd3, 3'd4, 1'b1}) begin
          bad++; $display("FAIL lw_memadr got=%b", {SrcB, ALUOP, ALUOutWrite});
        end
      end
      if (i == 3) begin
        total++;
        if ({MemRead, IorD, IRWrite} !== 3'b110) begin bad++; $display("FAIL lw_memrd got=%b exp=110", {MemRead, IorD, IRWrite}); end
      end
      if (i == 4) begin
        total++;
        if ({ACCWrite, ACCSrc} !== 2'b11) begin bad++; $display("FAIL lw_accld got=%b exp=11", {ACCWrite, ACCSrc}); end
      end
      step();
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0] ops [3] = '{4'h3, 4'h5, 4'h6};
    logic [2:0] exp_op [3] = '{3'd1, 3'd2, 3'd3};
    logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      Opcode = ops[k];
      for (int i = 0; i < 6; i++) begin
        total++;
        if (State !== seq[i]) begin bad++; $display("FAIL aluop%0h_state[%0d] got=%0d exp=%0d", ops[k], i, State, seq[i]); end
        if (i == 4) begin
          total++;
          if ({SrcA, SrcB, ALUOP} !== {3'd1, 4'd2, exp_op[k]}) begin
            bad++; $display("FAIL aluop%0h_aluex got=%b exp=%b", ops[k], {SrcA, SrcB, ALUOP}, {3'd1, 4'd2, exp_op[k]});
          end
        end
        step();
      end
    end
  endtask

  task automatic test_sw();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    do_reset();
    Opcode = 4'h1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (State !== seq[i]) begin bad++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, State, seq[i]); end
      if (i == 3) begin
        total++;
        if ({MemWrite, IorD, MemRead} !== 3'b110) begin bad++; $display("FAIL sw_memwr got=%b exp=110", {MemWrite, IorD, MemRead}); end
      end
      step();
    end
  endtask

  task automatic test_branch_jump();
    for (int z = 0; z < 2; z++) begin
      do_reset();
      Opcode = 4'h7;
      Zero = (z == 1);
      step(); step();
      total++;
      if (State !== 4'd8) begin bad++; $display("FAIL beqz%0d_state got=%0d exp=8", z, State); end
      total++;
      if ({PCWrite, PCSrc, SrcA, SrcB, ALUOP} !== {(z == 1), 1'b1, 3'd1, 4'd1, 3'd1}) begin
        bad++; $display("FAIL beqz%0d_outputs got=%b", z, {PCWrite, PCSrc, SrcA, SrcB, ALUOP});
      end
      step();
      total++;
      if (State !== 4'd0) begin bad++; $display("FAIL beqz%0d_return got=%0d exp=0", z, State); end
    end
    Zero = 1'b0;
    do_reset();
    Opcode = 4'h8;
    step(); step();
    total++;
    if ({State, PCWrite, PCSrc} !== {4'd9, 2'b11}) begin
      bad++; $display("FAIL jmp_outputs got=%b exp=100111", {State, PCWrite, PCSrc});
    end
    step();
    total++;
    if (State !== 4'd0) begin bad++; $display("FAIL jmp_return got=%0d exp=0", State); end
  endtask

  task automatic test_push_pop();
    logic [3:0] pseq [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    logic [3:0] qseq [5] = '{4'd1, 4'd12, 4'd13, 4'd4, 4'd0};
    int sp_writes = 0;
    do_reset();
    Opcode = 4'h9;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (State !== pseq[i]) begin bad++; $display("FAIL push_state[%0d] got=%0d exp=%0d", i, State, pseq[i]); end
      if (SPWrite) sp_writes++;
      if (i == 2) begin
        total++;
        if ({SrcA, SrcB, ALUOP, ALUOutWrite} !== {3'd2, 4'd0, 3'd1, 1'b1}) begin
          bad++; $display("FAIL push_spdec got=%b", {SrcA, SrcB, ALUOP, ALUOutWrite});
        end
      end
      if (i == 3) begin
        total++;
        if ({MemWrite, IorD} !== 2'b11) begin bad++; $display("FAIL push_wr got=%b exp=11", {MemWrite, IorD}); end
      end
      if (i < 4) step();
    end
    total++;
    if (sp_writes !== 1) begin bad++; $display("FAIL push_spwrite_count got=%0d exp=1", sp_writes); end
    Opcode = 4'hA;
    step();
    sp_writes = 0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (State !== qseq[i]) begin bad++; $display("FAIL pop_state[%0d] got=%0d exp=%0d", i, State, qseq[i]); end
      if (SPWrite) sp_writes++;
      if (i == 1) begin
        total++;
        if ({SrcA, SrcB, ALUOP, ALUOutWrite} !== {3'd2, 4'd0, 3'd0, 1'b1}) begin
          bad++; $display("FAIL pop_adr got=%b", {SrcA, SrcB, ALUOP, ALUOutWrite});
        end
      end
      if (i == 2) begin
        total++;
        if ({MemRead, IorD} !== 2'b11) begin bad++; $display("FAIL pop_rd got=%b exp=11", {MemRead, IorD}); end
      end
      if (i == 3) begin
        total++;
        if ({ACCWrite, ACCSrc} !== 2'b11) begin bad++; $display("FAIL pop_accld got=%b exp=11", {ACCWrite, ACCSrc}); end
      end
      step();
    end
    total++;
    if (sp_writes !== 1) begin bad++; $display("FAIL pop_spwrite_count got=%0d exp=1", sp_writes); end
  endtask

  task automatic test_halt_undef();
    do_reset();
    Opcode = 4'hF;
    step(); step();
    for (int i = 0; i < 20; i++) begin
      total++;
      if (State !== 4'd15 || Halted !== 1'b1 || strobes !== 10'd0) begin
        bad++; $display("FAIL halt_hold[%0d] state=%0d halted=%b strobes=%b", i, State, Halted, strobes);
      end
      step();
    end
    for (int op = 11; op <= 14; op++) begin
      do_reset();
      Opcode = 4'(op);
      step();
      total++;
      if (State !== 4'd1) begin bad++; $display("FAIL undef%0h_decode got=%0d exp=1", op, State); end
      step();
      total++;
      if (State !== 4'd0 || Halted !== 1'b0) begin
        bad++; $display("FAIL undef%0h_return state=%0d halted=%b exp=0/0", op, State, Halted);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_reset_mid_aluex();
    test_lw();
    test_alu_ops();
    test_sw();
    test_branch_jump();
    test_push_pop();
    test_halt_undef();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
